// File: rtl/writeback_controller.sv
// Writeback sequencer: captures one request, steers the writeback mux, waits out
// the source latency (fixed for RAM/timer, handshake + timeout for HD), pulses rf_we.
module writeback_controller #(
    parameter int RADDR_W    = 4,
    parameter int MEM_LAT    = 1,
    parameter int HD_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    input  logic [1:0]         req_src,
    input  logic [RADDR_W-1:0] req_rd,
    output logic               req_ready,
    output logic               stall,
    output logic [1:0]         wb_sel,
    output logic               hd_req,
    input  logic               hd_done,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic               wb_err
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam int TMR_W = $clog2(HD_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WAIT_HD  = 2'd2,
        WRITE    = 2'd3
    } state_t;

    localparam logic [1:0] SRC_ULA = 2'b00;
    localparam logic [1:0] SRC_HD  = 2'b11;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [1:0]         wb_sel_q, wb_sel_d;
    logic [RADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic               timer_expired;

    // The timer holds 0 in the first WAIT_HD cycle; expiry is the cycle it equals HD_TIMEOUT.
    assign timer_expired = (timer_q == TMR_W'(HD_TIMEOUT));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            timer_q    <= '0;
            wb_sel_q   <= '0;
            rf_waddr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            wb_sel_q   <= wb_sel_d;
            rf_waddr_q <= rf_waddr_d;
        end
    end

    // NOTE: every signal gets a hold-value default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        wb_sel_d   = wb_sel_q;
        rf_waddr_d = rf_waddr_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wb_sel_d   = req_src;
                    rf_waddr_d = req_rd;
                    cnt_d      = CNT_W'(MEM_LAT - 1);
                    timer_d    = '0;
                    if (req_src == SRC_ULA)     state_d = WRITE;
                    else if (req_src == SRC_HD) state_d = WAIT_HD;
                    else                        state_d = WAIT_MEM;
                end
            end
            WAIT_MEM: begin
                if (cnt_q == '0) state_d = WRITE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            WAIT_HD: begin
                // A late hd_done on the expiry cycle still counts as a completed read.
                if (hd_done)            state_d = WRITE;
                else if (timer_expired) state_d = IDLE;
                else                    timer_d = timer_q + TMR_W'(1);
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        stall     = req_valid && (state_q != IDLE);
        hd_req    = (state_q == WAIT_HD) && (timer_q == '0);
        rf_we     = (state_q == WRITE);
        wb_err    = (state_q == WAIT_HD) && timer_expired && !hd_done;
        wb_sel    = wb_sel_q;
        rf_waddr  = rf_waddr_q;
    end

endmodule

// File: tb/tb_writeback_controller.sv
// Directed bench for writeback_controller: instance a (MEM_LAT=3, HD_TIMEOUT=255)
// and instance b (MEM_LAT=1, HD_TIMEOUT=4) share clock and reset.
module tb_writeback_controller;

    logic clk = 1'b0;
    logic rst_n;
    int   total  = 0;
    int   passed = 0;

    logic       a_req_valid, a_hd_done, a_req_ready, a_stall, a_hd_req, a_rf_we, a_wb_err;
    logic [1:0] a_req_src, a_wb_sel;
    logic [3:0] a_req_rd, a_rf_waddr;
    logic       b_req_valid, b_hd_done, b_req_ready, b_stall, b_hd_req, b_rf_we, b_wb_err;
    logic [1:0] b_req_src, b_wb_sel;
    logic [3:0] b_req_rd, b_rf_waddr;

    always #5 clk = ~clk;

    writeback_controller #(.RADDR_W(4), .MEM_LAT(3), .HD_TIMEOUT(255)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_src(a_req_src),
        .req_rd(a_req_rd), .req_ready(a_req_ready), .stall(a_stall), .wb_sel(a_wb_sel),
        .hd_req(a_hd_req), .hd_done(a_hd_done), .rf_we(a_rf_we), .rf_waddr(a_rf_waddr),
        .wb_err(a_wb_err)
    );

    writeback_controller #(.RADDR_W(4), .MEM_LAT(1), .HD_TIMEOUT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_src(b_req_src),
        .req_rd(b_req_rd), .req_ready(b_req_ready), .stall(b_stall), .wb_sel(b_wb_sel),
        .hd_req(b_hd_req), .hd_done(b_hd_done), .rf_we(b_rf_we), .rf_waddr(b_rf_waddr),
        .wb_err(b_wb_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({a_req_ready, a_stall, a_wb_sel, a_rf_waddr, a_rf_we, a_hd_req, a_wb_err} !== 11'b1_0_00_0000_000)
            $display("FAIL reset_a: got rdy/stall/sel/waddr/we/hdreq/err=%b expected 10000000000",
                     {a_req_ready, a_stall, a_wb_sel, a_rf_waddr, a_rf_we, a_hd_req, a_wb_err});
        else passed++;
        total++;
        if ({b_req_ready, b_wb_sel, b_rf_waddr, b_rf_we, b_wb_err} !== 9'b1_00_0000_00)
            $display("FAIL reset_b: got %b expected 100000000",
                     {b_req_ready, b_wb_sel, b_rf_waddr, b_rf_we, b_wb_err});
        else passed++;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ula();
        a_req_valid = 1'b1; a_req_src = 2'b00; a_req_rd = 4'd5;
        #1;
        total++;
        if (a_stall !== 1'b0) $display("FAIL ula_stall_idle: got %b expected 0", a_stall);
        else passed++;
        tick();
        a_req_valid = 1'b0;
        total++;
        if ({a_rf_we, a_rf_waddr, a_wb_sel, a_req_ready} !== 8'b1_0101_00_0)
            $display("FAIL ula_write: got we/waddr/sel/rdy=%b expected 10101000",
                     {a_rf_we, a_rf_waddr, a_wb_sel, a_req_ready});
        else passed++;
        tick();
        total++;
        if ({a_rf_we, a_req_ready, a_rf_waddr} !== 6'b0_1_0101)
            $display("FAIL ula_after: got we/rdy/waddr=%b expected 010101", {a_rf_we, a_req_ready, a_rf_waddr});
        else passed++;
    endtask

    // Second request (src 00, rd 9) is held throughout; it must wait and be accepted after WRITE.
    task automatic test_mem_latency();
        a_req_valid = 1'b1; a_req_src = 2'b01; a_req_rd = 4'd7;
        tick();
        a_req_src = 2'b00; a_req_rd = 4'd9; a_hd_done = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            total++;
            if ({a_rf_we, a_stall, a_wb_sel, a_rf_waddr, a_hd_req} !== {(c == 4), 1'b1, 2'b01, 4'd7, 1'b0})
                $display("FAIL mem_cycle%0d: got we/stall/sel/waddr/hdreq=%b expected %b", c,
                         {a_rf_we, a_stall, a_wb_sel, a_rf_waddr, a_hd_req},
                         {(c == 4), 1'b1, 2'b01, 4'd7, 1'b0});
            else passed++;
            if (c == 3) a_hd_done = 1'b0;
            tick();
        end
        total++;
        if ({a_req_ready, a_stall, a_rf_we, a_wb_sel, a_rf_waddr} !== 9'b1_0_0_01_0111)
            $display("FAIL mem_idle: got rdy/stall/we/sel/waddr=%b expected 100010111",
                     {a_req_ready, a_stall, a_rf_we, a_wb_sel, a_rf_waddr});
        else passed++;
        tick();
        a_req_valid = 1'b0;
        total++;
        if ({a_rf_we, a_wb_sel, a_rf_waddr} !== 7'b1_00_1001)
            $display("FAIL mem_queued_write: got we/sel/waddr=%b expected 1001001", {a_rf_we, a_wb_sel, a_rf_waddr});
        else passed++;
        tick();
    endtask

    task automatic test_hd_done();
        a_req_valid = 1'b1; a_req_src = 2'b11; a_req_rd = 4'd12;
        tick();
        a_req_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            total++;
            if ({a_hd_req, a_rf_we, a_wb_err, a_wb_sel, a_req_ready} !== {(c == 1), 2'b00, 2'b11, 1'b0})
                $display("FAIL hd_wait%0d: got hdreq/we/err/sel/rdy=%b expected %b", c,
                         {a_hd_req, a_rf_we, a_wb_err, a_wb_sel, a_req_ready}, {(c == 1), 2'b00, 2'b11, 1'b0});
            else passed++;
            if (c == 10) a_hd_done = 1'b1;
            tick();
        end
        a_hd_done = 1'b0;
        total++;
        if ({a_rf_we, a_wb_err, a_rf_waddr, a_wb_sel} !== 8'b1_0_1100_11)
            $display("FAIL hd_write: got we/err/waddr/sel=%b expected 10110011", {a_rf_we, a_wb_err, a_rf_waddr, a_wb_sel});
        else passed++;
        tick();
        total++;
        if ({a_req_ready, a_rf_we} !== 2'b10)
            $display("FAIL hd_after: got rdy/we=%b expected 10", {a_req_ready, a_rf_we});
        else passed++;
    endtask

    // HD_TIMEOUT=4: timer runs 0..4, so the fifth WAIT_HD cycle is the expiry cycle.
    task automatic test_hd_timeout();
        for (int pass = 0; pass < 2; pass++) begin
            b_req_valid = 1'b1; b_req_src = 2'b11; b_req_rd = 4'd3;
            tick();
            b_req_valid = 1'b0;
            for (int c = 1; c <= 5; c++) begin
                if (c == 5 && pass == 1) b_hd_done = 1'b1;
                #1;
                total++;
                if ({b_wb_err, b_rf_we, b_hd_req} !== {(c == 5 && pass == 0), 1'b0, (c == 1)})
                    $display("FAIL hd_to_p%0d_c%0d: got err/we/hdreq=%b expected %b", pass, c,
                             {b_wb_err, b_rf_we, b_hd_req}, {(c == 5 && pass == 0), 1'b0, (c == 1)});
                else passed++;
                tick();
            end
            b_hd_done = 1'b0;
            total++;
            if ({b_rf_we, b_wb_err, b_req_ready} !== {(pass == 1), 1'b0, (pass == 0)})
                $display("FAIL hd_to_end_p%0d: got we/err/rdy=%b expected %b", pass,
                         {b_rf_we, b_wb_err, b_req_ready}, {(pass == 1), 1'b0, (pass == 0)});
            else passed++;
            tick();
        end
        // MEM_LAT=1 on this instance: write lands in N+2.
        b_req_valid = 1'b1; b_req_src = 2'b10; b_req_rd = 4'd4;
        tick();
        b_req_valid = 1'b0;
        total++;
        if ({b_rf_we, b_wb_sel} !== 3'b0_10) $display("FAIL mem1_wait: got we/sel=%b expected 010", {b_rf_we, b_wb_sel});
        else passed++;
        tick();
        total++;
        if ({b_rf_we, b_rf_waddr} !== 5'b1_0100) $display("FAIL mem1_write: got we/waddr=%b expected 10100", {b_rf_we, b_rf_waddr});
        else passed++;
        tick();
    endtask

    task automatic test_back_to_back();
        a_hd_done = 1'b1;
        for (int c = 0; c < 2; c++) begin
            total++;
            if ({a_hd_req, a_rf_we, a_req_ready, a_wb_err} !== 4'b0010)
                $display("FAIL stray_hd_idle%0d: got hdreq/we/rdy/err=%b expected 0010", c,
                         {a_hd_req, a_rf_we, a_req_ready, a_wb_err});
            else passed++;
            tick();
        end
        a_hd_done = 1'b0;
        a_req_valid = 1'b1; a_req_src = 2'b00; a_req_rd = 4'd1;
        tick();
        a_req_rd = 4'd2;
        total++;
        if ({a_rf_we, a_rf_waddr} !== 5'b1_0001) $display("FAIL b2b_w1: got we/waddr=%b expected 10001", {a_rf_we, a_rf_waddr});
        else passed++;
        tick();
        total++;
        if ({a_rf_we, a_req_ready, a_rf_waddr} !== 6'b0_1_0001)
            $display("FAIL b2b_gap: got we/rdy/waddr=%b expected 010001", {a_rf_we, a_req_ready, a_rf_waddr});
        else passed++;
        tick();
        a_req_valid = 1'b0;
        total++;
        if ({a_rf_we, a_rf_waddr} !== 5'b1_0010) $display("FAIL b2b_w2: got we/waddr=%b expected 10010", {a_rf_we, a_rf_waddr});
        else passed++;
        tick();
    endtask

    task automatic test_reset_mid_hd();
        a_req_valid = 1'b1; a_req_src = 2'b11; a_req_rd = 4'd6;
        tick();
        a_req_valid = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        total++;
        if ({a_req_ready, a_wb_sel, a_rf_waddr, a_rf_we, a_hd_req, a_wb_err} !== 10'b1_00_0000_000)
            $display("FAIL rst_mid_hd: got rdy/sel/waddr/we/hdreq/err=%b expected 1000000000",
                     {a_req_ready, a_wb_sel, a_rf_waddr, a_rf_we, a_hd_req, a_wb_err});
        else passed++;
        tick();
        rst_n = 1'b1;
        a_hd_done = 1'b1;
        tick();
        a_hd_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            total++;
            if ({a_req_ready, a_rf_we, a_wb_err} !== 3'b100)
                $display("FAIL rst_after%0d: got rdy/we/err=%b expected 100", c, {a_req_ready, a_rf_we, a_wb_err});
            else passed++;
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_req_valid = 1'b0; a_req_src = 2'b00; a_req_rd = 4'd0; a_hd_done = 1'b0;
        b_req_valid = 1'b0; b_req_src = 2'b00; b_req_rd = 4'd0; b_hd_done = 1'b0;
        test_reset();
        test_ula();
        test_mem_latency();
        test_hd_done();
        test_hd_timeout();
        test_back_to_back();
        test_reset_mid_hd();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
